// File: rtl/stream_burst_arbiter.sv
// Multi-channel pixel stream arbiter: per-channel FIFOs with overflow/drop handling,
// round-robin burst grants that never split a frame start from the head of a burst.
module stream_burst_arbiter #(
  parameter  int NUM_CH     = 2,
  parameter  int DATA_W     = 15,
  parameter  int FIFO_DEPTH = 16,
  parameter  int BURST      = 8,
  localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [NUM_CH*DATA_W-1:0] in_st_data,
  input  logic [NUM_CH-1:0]        in_st_start,
  input  logic [NUM_CH-1:0]        in_st_dv,
  output logic [DATA_W-1:0]        out_st_data,
  output logic                     out_st_start,
  output logic [CH_W-1:0]          out_st_chan,
  output logic                     out_st_dv,
  input  logic                     out_st_ready,
  output logic [NUM_CH-1:0]        ovf_flag,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int WW = DATA_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BURST} state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WW-1:0]     r_mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     r_wr_ptr [NUM_CH];
  logic [AW-1:0]     r_rd_ptr [NUM_CH];
  logic [CW-1:0]     r_count  [NUM_CH];
  logic [NUM_CH-1:0] r_drop;
  logic [NUM_CH-1:0] r_ovf;
  logic [CH_W-1:0]   r_grant;
  logic [BW-1:0]     r_beats;

  logic [NUM_CH-1:0] w_full;
  logic [NUM_CH-1:0] w_empty;
  logic [NUM_CH-1:0] w_wr;
  logic [NUM_CH-1:0] w_rd;
  logic [NUM_CH-1:0] w_ovf_set;
  logic              w_xfer;
  logic [AW-1:0]     w_rd_ptr_nxt;
  logic [WW-1:0]     w_head;
  logic              w_next_start;
  logic [CW-1:0]     w_gcnt_nxt;
  logic              w_burst_end;
  logic [CH_W-1:0]   w_cand;
  logic [CH_W-1:0]   w_sel;
  logic              w_sel_vld;

  // Full is judged on the pre-cycle count, so a same-cycle pop never rescues a write.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_full    = '0;
    w_empty   = '0;
    w_wr      = '0;
    w_rd      = '0;
    w_ovf_set = '0;
    w_xfer    = (r_state == S_BURST) && out_st_ready;
    for (int k = 0; k < NUM_CH; k++) begin
      w_full[k]    = (r_count[k] == CW'(FIFO_DEPTH));
      w_empty[k]   = (r_count[k] == '0);
      w_wr[k]      = in_st_dv[k] && !w_full[k] && (!r_drop[k] || in_st_start[k]);
      w_ovf_set[k] = in_st_dv[k] && w_full[k] && !r_drop[k];
      w_rd[k]      = w_xfer && (r_grant == CH_W'(k));
    end
  end

  // The word following the popped one decides whether a frame start closes the burst.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr[r_grant] + AW'(1);
    w_head       = r_mem[r_grant][r_rd_ptr[r_grant]];
    w_next_start = (r_count[r_grant] > CW'(1)) ? r_mem[r_grant][w_rd_ptr_nxt][DATA_W]
                                               : in_st_start[r_grant];
    w_gcnt_nxt   = r_count[r_grant] + CW'(w_wr[r_grant]) - CW'(1);
    w_burst_end  = w_xfer && ((r_beats == BW'(BURST - 1)) || (w_gcnt_nxt == '0) || w_next_start);
  end

  always_comb begin
    w_sel_vld = 1'b0;
    w_sel     = '0;
    w_cand    = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = CH_W'((int'(r_grant) + i) % NUM_CH);
      if (!w_sel_vld && !w_empty[w_cand]) begin
        w_sel_vld = 1'b1;
        w_sel     = w_cand;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    out_st_dv    = 1'b0;
    out_st_data  = '0;
    out_st_start = 1'b0;
    out_st_chan  = '0;
    case (r_state)
      S_IDLE:  if (|(~w_empty)) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = w_sel_vld ? S_BURST : S_IDLE;
      S_BURST: begin
        out_st_dv    = 1'b1;
        out_st_data  = w_head[DATA_W-1:0];
        out_st_start = w_head[DATA_W];
        out_st_chan  = r_grant;
        if (w_burst_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Pointer reset to the last channel makes channel 0 the first one searched.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_grant <= CH_W'(NUM_CH - 1);
      r_beats <= '0;
      r_drop  <= '1;
      r_ovf   <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_wr_ptr[k] <= '0;
        r_rd_ptr[k] <= '0;
        r_count[k]  <= '0;
      end
    end else begin
      if (r_state == S_GRANT) begin
        if (w_sel_vld) r_grant <= w_sel;
        r_beats <= '0;
      end else if (w_xfer) begin
        r_beats <= r_beats + BW'(1);
      end
      r_ovf <= (r_ovf & ~{NUM_CH{ovf_clr}}) | w_ovf_set;
      for (int k = 0; k < NUM_CH; k++) begin
        if (w_wr[k]) r_wr_ptr[k] <= r_wr_ptr[k] + AW'(1);
        if (w_rd[k]) r_rd_ptr[k] <= r_rd_ptr[k] + AW'(1);
        r_count[k] <= r_count[k] + CW'(w_wr[k]) - CW'(w_rd[k]);
        if (w_ovf_set[k])           r_drop[k] <= 1'b1;
        else if (w_wr[k] && r_drop[k]) r_drop[k] <= 1'b0;
      end
    end
  end

  // NOTE: storage has no reset; the pointers and counts alone define what is valid.
  always_ff @(posedge clk_clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_wr[k]) r_mem[k][r_wr_ptr[k]] <= {in_st_start[k], in_st_data[k*DATA_W +: DATA_W]};
    end
  end

  assign ovf_flag = r_ovf;

endmodule

// File: tb/tb_stream_burst_arbiter.sv
// Self-checking bench for stream_burst_arbiter: queue-based reference model checked
// every cycle, plus directed scenarios for frame alignment, burst order and overflow.
module tb_stream_burst_arbiter;

  localparam int NUM_CH     = 2;
  localparam int DATA_W     = 15;
  localparam int FIFO_DEPTH = 16;
  localparam int BURST      = 8;
  localparam int CH_W       = 1;

  logic                     clk_clk = 1'b0;
  logic                     reset_reset_n;
  logic [NUM_CH*DATA_W-1:0] in_st_data;
  logic [NUM_CH-1:0]        in_st_start;
  logic [NUM_CH-1:0]        in_st_dv;
  logic [DATA_W-1:0]        out_st_data;
  logic                     out_st_start;
  logic [CH_W-1:0]          out_st_chan;
  logic                     out_st_dv;
  logic                     out_st_ready;
  logic [NUM_CH-1:0]        ovf_flag;
  logic                     ovf_clr;

  always #5 clk_clk = ~clk_clk;

  stream_burst_arbiter #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .BURST(BURST)
  ) dut (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .in_st_data   (in_st_data),
    .in_st_start  (in_st_start),
    .in_st_dv     (in_st_dv),
    .out_st_data  (out_st_data),
    .out_st_start (out_st_start),
    .out_st_chan  (out_st_chan),
    .out_st_dv    (out_st_dv),
    .out_st_ready (out_st_ready),
    .ovf_flag     (ovf_flag),
    .ovf_clr      (ovf_clr)
  );

  // Reference model: one queue of {start,data} per channel plus burst bookkeeping.
  logic [DATA_W:0]   mq [NUM_CH][$];
  logic [NUM_CH-1:0] m_drop;
  logic [NUM_CH-1:0] m_ovf;
  bit                m_busy;
  bit                m_pending;
  int                m_ch;
  int                m_last;
  int                m_sent;

  logic [DATA_W-1:0] obs_data  [$];
  bit                obs_start [$];
  int                obs_chan  [$];
  int                obs_t     [$];

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_CH; k++) mq[k].delete();
    m_drop    = '1;
    m_ovf     = '0;
    m_busy    = 1'b0;
    m_pending = 1'b0;
    m_ch      = 0;
    m_last    = NUM_CH - 1;
    m_sent    = 0;
  endtask

  function automatic bit model_idle();
    bit any = 1'b0;
    for (int k = 0; k < NUM_CH; k++) if (mq[k].size() != 0) any = 1'b1;
    return !m_busy && !m_pending && !any;
  endfunction

  task automatic clear_obs();
    obs_data.delete(); obs_start.delete(); obs_chan.delete(); obs_t.delete();
  endtask

  // Check outputs mid-cycle, advance the model across the coming edge, then return #1 after it.
  task automatic step();
    logic [NUM_CH-1:0] pre_ne, pre_full, push, ovf_set;
    logic [DATA_W:0]   head;
    bit                xfer;
    @(negedge clk_clk);
    check("dv", {31'd0, out_st_dv}, {31'd0, m_busy});
    if (m_busy && mq[m_ch].size() > 0) begin
      head = mq[m_ch][0];
      check("data",  {17'd0, out_st_data}, {17'd0, head[DATA_W-1:0]});
      check("start", {31'd0, out_st_start}, {31'd0, head[DATA_W]});
      check("chan",  {31'd0, out_st_chan}, 32'(m_ch));
    end
    check("ovf", {30'd0, ovf_flag}, {30'd0, m_ovf});
    if (out_st_dv && out_st_ready && reset_reset_n) begin
      obs_data.push_back(out_st_data);
      obs_start.push_back(out_st_start);
      obs_chan.push_back(int'(out_st_chan));
      obs_t.push_back(cyc);
    end
    if (!reset_reset_n) begin
      model_reset();
    end else begin
      push = '0; ovf_set = '0;
      for (int k = 0; k < NUM_CH; k++) begin
        pre_ne[k]   = (mq[k].size() != 0);
        pre_full[k] = (mq[k].size() == FIFO_DEPTH);
        if (in_st_dv[k]) begin
          if (m_drop[k]) begin
            if (in_st_start[k] && !pre_full[k]) begin push[k] = 1'b1; m_drop[k] = 1'b0; end
          end else if (pre_full[k]) begin
            ovf_set[k] = 1'b1; m_drop[k] = 1'b1;
          end else begin
            push[k] = 1'b1;
          end
        end
      end
      m_ovf = (ovf_clr ? '0 : m_ovf) | ovf_set;
      xfer = m_busy && out_st_ready;
      if (m_busy) begin
        if (xfer) begin void'(mq[m_ch].pop_front()); m_sent++; end
      end else if (!m_pending) begin
        if (|pre_ne) m_pending = 1'b1;
      end else begin
        for (int i = 1; i <= NUM_CH; i++) begin
          if (m_pending && pre_ne[(m_last + i) % NUM_CH]) begin
            m_ch = (m_last + i) % NUM_CH;
            m_pending = 1'b0;
          end
        end
        m_last = m_ch; m_busy = 1'b1; m_sent = 0; m_pending = 1'b0;
      end
      for (int k = 0; k < NUM_CH; k++)
        if (push[k]) mq[k].push_back({in_st_start[k], in_st_data[k*DATA_W +: DATA_W]});
      if (xfer) begin
        if (m_sent == BURST || mq[m_ch].size() == 0) m_busy = 1'b0;
        else begin head = mq[m_ch][0]; if (head[DATA_W]) m_busy = 1'b0; end
      end
    end
    cyc++;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic clear_in();
    in_st_dv = '0; in_st_start = '0; in_st_data = '0; ovf_clr = 1'b0;
  endtask

  task automatic set_ch(input int ch, input bit s, input logic [DATA_W-1:0] d);
    in_st_dv[ch] = 1'b1; in_st_start[ch] = s; in_st_data[ch*DATA_W +: DATA_W] = d;
  endtask

  task automatic send1(input int ch, input bit s, input logic [DATA_W-1:0] d);
    set_ch(ch, s, d); step(); clear_in();
  endtask

  task automatic do_reset();
    clear_in();
    reset_reset_n = 1'b0;
    step();
    check("rst_dv",    {31'd0, out_st_dv}, 32'd0);
    check("rst_data",  {17'd0, out_st_data}, 32'd0);
    check("rst_start", {31'd0, out_st_start}, 32'd0);
    check("rst_chan",  {31'd0, out_st_chan}, 32'd0);
    check("rst_ovf",   {30'd0, ovf_flag}, 32'd0);
    reset_reset_n = 1'b1;
  endtask

  task automatic drain();
    int g = 0;
    while (!model_idle() && g < 400) begin step(); g++; end
    if (g >= 400) check("drain_timeout", 32'd1, 32'd0);
    repeat (3) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] sent [8];
    int c0, g, exp_ch;
    model_reset();
    clear_in();
    out_st_ready  = 1'b1;
    reset_reset_n = 1'b0;
    @(posedge clk_clk); #1;

    // Capture starts at the first frame start; non-start words before it vanish.
    do_reset();
    clear_obs();
    for (int i = 0; i < 3; i++) send1(0, 1'b0, DATA_W'(16'h0100 + i));
    c0 = cyc;
    send1(0, 1'b1, 15'h1A2B);
    send1(0, 1'b0, 15'h0011);
    send1(0, 1'b0, 15'h0022);
    drain();
    check("r034_n", 32'(obs_data.size()), 32'd3);
    if (obs_data.size() >= 3) begin
      check("r034_d0", {17'd0, obs_data[0]}, 32'h1A2B);
      check("r034_s0", {31'd0, obs_start[0]}, 32'd1);
      check("r034_s1", {31'd0, obs_start[1]}, 32'd0);
      check("r034_d2", {17'd0, obs_data[2]}, 32'h0022);
      check("r034_c",  32'(obs_chan[0] + obs_chan[1] + obs_chan[2]), 32'd0);
      check("r027_lat", 32'(obs_t[0] - c0 <= 3), 32'd1);
    end

    // Two full-ish channels drained with ready high: 8/8/4/4 round-robin.
    out_st_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      set_ch(0, i == 0, DATA_W'(16'h0200 + i));
      set_ch(1, i == 0, DATA_W'(16'h0300 + i));
      step();
      clear_in();
    end
    clear_obs();
    out_st_ready = 1'b1;
    drain();
    check("r035_n", 32'(obs_chan.size()), 32'd24);
    if (obs_chan.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        exp_ch = (i < 8) ? 0 : (i < 16) ? 1 : (i < 20) ? 0 : 1;
        check("r035_chan", 32'(obs_chan[i]), 32'(exp_ch));
        if (i > 0)
          check("r035_gap", 32'(obs_t[i] - obs_t[i-1]),
                (i == 8 || i == 16 || i == 20) ? 32'd3 : 32'd1);
      end
    end

    // A frame start inside the FIFO splits the data into 3 + 2 word bursts.
    out_st_ready = 1'b0;
    do_reset();
    send1(0, 1'b1, 15'h0401);
    send1(0, 1'b0, 15'h0402);
    send1(0, 1'b0, 15'h0403);
    send1(0, 1'b1, 15'h0404);
    send1(0, 1'b0, 15'h0405);
    clear_obs();
    out_st_ready = 1'b1;
    drain();
    check("r036_n", 32'(obs_data.size()), 32'd5);
    if (obs_data.size() == 5) begin
      check("r036_b1",  32'(obs_t[2] - obs_t[0]), 32'd2);
      check("r036_gap", 32'(obs_t[3] - obs_t[2]), 32'd3);
      check("r036_s3",  {31'd0, obs_start[3]}, 32'd1);
      check("r036_d3",  {17'd0, obs_data[3]}, 32'h0404);
    end

    // Backpressure mid-burst: word held, nothing lost or repeated.
    out_st_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sent[i] = DATA_W'($urandom);
      send1(0, i == 0, sent[i]);
    end
    clear_obs();
    out_st_ready = 1'b1;
    repeat (3) step();
    out_st_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check("r037_dv",   {31'd0, out_st_dv}, 32'd1);
      check("r037_hold", {17'd0, out_st_data}, {17'd0, sent[3]});
    end
    out_st_ready = 1'b1;
    drain();
    check("r037_n", 32'(obs_data.size()), 32'd8);
    if (obs_data.size() == 8)
      for (int i = 0; i < 8; i++) check("r037_seq", {17'd0, obs_data[i]}, {17'd0, sent[i]});

    // Overflow on ch1, drop until next start, set beats a coincident clear.
    out_st_ready = 1'b0;
    do_reset();
    clear_obs();
    for (int i = 0; i < 20; i++) send1(1, i == 0, DATA_W'(16'h0500 + i));
    check("r038_ovf", {31'd0, ovf_flag[1]}, 32'd1);
    for (int i = 0; i < 3; i++) send1(1, 1'b0, DATA_W'(16'h0600 + i));
    ovf_clr = 1'b1; step(); clear_in();
    check("r038_clr", {31'd0, ovf_flag[1]}, 32'd0);
    out_st_ready = 1'b1;
    repeat (4) step();
    out_st_ready = 1'b0;
    for (int i = 0; i < 4; i++) send1(1, i == 0, DATA_W'(16'h0700 + i));
    set_ch(1, 1'b0, 15'h0777); ovf_clr = 1'b1; step(); clear_in();
    check("r038_setwins", {31'd0, ovf_flag[1]}, 32'd1);
    out_st_ready = 1'b1;
    drain();
    check("r038_n", 32'(obs_data.size()), 32'd20);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        in_st_dv[k]    = ($urandom_range(0, 99) < 45);
        in_st_start[k] = ($urandom_range(0, 5) == 0);
        in_st_data[k*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      out_st_ready = ($urandom_range(0, 3) != 0);
      ovf_clr      = ($urandom_range(0, 29) == 0);
      step();
    end
    clear_in();

    // Reset in the middle of a burst.
    out_st_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      set_ch(0, i == 0, DATA_W'($urandom));
      set_ch(1, i == 0, DATA_W'($urandom));
      step();
      clear_in();
    end
    out_st_ready = 1'b1;
    g = 0;
    while (!out_st_dv && g < 20) begin step(); g++; end
    check("r039_busy", {31'd0, out_st_dv}, 32'd1);
    step();
    reset_reset_n = 1'b0;
    step();
    check("r039_dv",  {31'd0, out_st_dv}, 32'd0);
    check("r039_ovf", {30'd0, ovf_flag}, 32'd0);
    reset_reset_n = 1'b1;
    clear_obs();
    repeat (10) step();
    check("r039_empty", 32'(obs_data.size()), 32'd0);
    send1(1, 1'b1, 15'h0ABC);
    drain();
    check("r039_after", 32'(obs_data.size()), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/stream_burst_arbiter.md
STREAM_BURST_ARBITER -- requirements
Module: stream_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of input pixel streams, range 1..8.
REQ-002 SHALL have parameter DATA_W, default 15: pixel word width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: per-channel FIFO depth in words, power of two, at least 4.
REQ-004 SHALL have parameter BURST, default 8: maximum words per grant, range 1..FIFO_DEPTH.
REQ-005 SHALL derive CH_W = max(1, ceil(log2(NUM_CH))).
REQ-006 clk_clk  in  1  single clock; one clock, all logic on its rising edge.
REQ-007 reset_reset_n  in  1  reset, synchronous, active-low.
REQ-008 in_st_data  in  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
REQ-009 in_st_start  in  NUM_CH  per channel, marks the first pixel of a frame; qualified by in_st_dv.
REQ-010 in_st_dv  in  NUM_CH  per-channel word valid; there is no backpressure on inputs.
REQ-011 out_st_data  out  DATA_W  granted word.
REQ-012 out_st_start  out  1  start flag carried with the word.
REQ-013 out_st_chan  out  CH_W  source channel of the word.
REQ-014 out_st_dv  out  1  output valid.
REQ-015 out_st_ready  in  1  sink accepts the word; a transfer occurs on a cycle with out_st_dv=1 and out_st_ready=1.
REQ-016 ovf_flag  out  NUM_CH  sticky per-channel overflow flag.
REQ-017 ovf_clr  in  1  single-cycle clear of all ovf_flag bits.

Function
REQ-018 Each channel SHALL have a FIFO DATA_W+1 wide, storing the start bit alongside the data.
- Writes occur on in_st_dv only when the channel is not dropping.
REQ-019 Full SHALL be evaluated on the pre-cycle count.
- A write to a full FIFO is dropped even if a read happens in the same cycle.
- Simultaneous read and write on a non-full, non-empty FIFO SHALL leave the count unchanged.
REQ-020 A dropped write SHALL set ovf_flag[k] and put channel k in DROP mode.
- DROP mode discards words until a word with in_st_start=1 arrives while the FIFO is not full.
- That word is written and DROP mode exits.
REQ-021 If ovf_flag set and ovf_clr occur in the same cycle, set SHALL win.
REQ-022 The arbiter SHALL have states IDLE, GRANT and BURST.
REQ-023 IDLE->GRANT when any FIFO is non-empty.
- GRANT selects, round-robin, the first non-empty channel after the last granted channel, then goes to BURST.
REQ-024 BURST SHALL present the head of the granted FIFO with out_st_dv=1 and pop it on each transfer.
REQ-025 BURST SHALL end, returning to IDLE, on whichever comes first:
- BURST words transferred;
- the FIFO empties;
- the next head word has start=1 and is not the burst's first word.
- Frame starts therefore always open a burst.
REQ-026 While out_st_dv=1 and out_st_ready=0, out_st_data, out_st_start and out_st_chan SHALL be held stable.
- out_st_dv SHALL NOT drop without a transfer.
REQ-027 Latency: with the arbiter IDLE, out_st_ready=1 and only one channel active, a word sampled on in_st_dv SHALL appear with out_st_dv=1 within 3 cycles.
REQ-028 With out_st_ready held high, a burst SHALL sustain one transfer per cycle.
REQ-029 out_st_dv SHALL be 0 in IDLE and GRANT.
REQ-030 out_st_chan SHALL equal the granted channel for the whole burst.

Reset
REQ-031 While reset_reset_n=0 at a clock edge, the block SHALL:
- empty all FIFOs;
- set state=IDLE;
- set the round-robin pointer so that channel 0 is searched first;
- set out_st_dv, out_st_data, out_st_start, out_st_chan and ovf_flag to 0.
REQ-032 After reset every channel SHALL be in DROP mode, so that capture begins at the first in_st_start.
REQ-033 Reset asserted mid-burst SHALL abort the burst in the next cycle.
- No further transfers occur.
- Partial FIFO contents are discarded.

Verification
REQ-034 Reset release, ch0 sends 3 words with no start, then a start word 0x1A2B plus 2 more -> only the 3 words from 0x1A2B onward are output, out_st_start=1 on the first only, out_st_chan=0.
REQ-035 NUM_CH=2, BURST=8, both FIFOs holding 12 words, ready high -> output order is ch0×8, ch1×8, ch0×4, ch1×4, with 1 transfer per cycle inside each burst.
REQ-036 ch0 FIFO holding 5 words, where the 4th has start=1 -> first burst is 3 words, second burst of 2 words starts with out_st_start=1.
REQ-037 out_st_ready low for 5 cycles mid-burst -> out_st_dv stays 1 with data unchanged, and no word is lost or duplicated on resume.
REQ-038 ch1 receives 20 words (FIFO_DEPTH=16) with ready low -> 16 stored, ovf_flag[1]=1, later words discarded until the next start; ovf_clr coinciding with a fresh overflow leaves the flag at 1.
REQ-039 reset_reset_n pulsed low during a burst -> out_st_dv=0 the next cycle, all FIFOs empty, ovf_flag=0.
